mp3_ctrl_panel: RTL and testbench

//  User-control stage directly upstream of the VS1003 SPI driver: turns five raw push-buttons into the

---
 rtl/mp3_ctrl_panel.sv | 173 +++++++++++++++++
 tb/tb_mp3_ctrl_panel.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mp3_ctrl_panel.sv
// Button front end for the VS1003 driver: debounces five push-buttons and turns them into
// a registered {att,att} volume word, a track index, a mute flag and a change pulse.
module mp3_ctrl_panel #(
  parameter int         DEBOUNCE_CYCLES = 2_000_000,
  parameter int         REPEAT_DELAY    = 50_000_000,
  parameter int         REPEAT_RATE     = 10_000_000,
  parameter logic [7:0] VOL_STEP        = 8'h10,
  parameter logic [7:0] VOL_INIT        = 8'h66,
  parameter logic [7:0] VOL_MAX_ATT     = 8'hFE,
  parameter int         NUM_TRACKS      = 3
) (
  input  logic        clk,
  input  logic        init,
  input  logic        btn_louder,
  input  logic        btn_quieter,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic        btn_mute,
  output logic [15:0] volume,
  output logic [1:0]  num,
  output logic        muted,
  output logic        upd
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DB_LOAD    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LOAD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LOAD  = RW'(REPEAT_RATE - 1);
  localparam logic [1:0]    LAST_TRACK = 2'(NUM_TRACKS - 1);

  // RP_IDLE: released | RP_HOLD: waiting for first repeat | RP_REPEAT: repeating at rate
  typedef enum logic [1:0] {RP_IDLE, RP_HOLD, RP_REPEAT} rep_state_t;

  // bit order: 0 louder, 1 quieter, 2 next, 3 prev, 4 mute
  logic [4:0]    w_raw;
  logic [4:0]    r_sync1, r_sync2, r_deb, r_deb_d, r_ev;
  logic [DW-1:0] r_dcnt [5];

  rep_state_t    r_rstate [2];
  rep_state_t    w_rstate_nxt [2];
  logic [RW-1:0] r_rcnt [2];
  logic [RW-1:0] w_rcnt_nxt [2];
  logic [1:0]    w_rep;

  logic [7:0]  r_att, w_att_nxt, w_att_dn, w_att_up;
  logic [8:0]  w_att_sum;
  logic        r_muted, w_muted_nxt;
  logic [1:0]  r_num, w_num_nxt, w_num_inc, w_num_dec;
  logic [15:0] r_volume, w_vol_nxt;
  logic        r_upd;
  logic        w_loud, w_quiet;

  assign w_raw = {btn_mute, btn_prev, btn_next, btn_quieter, btn_louder};

  always_ff @(posedge clk) begin
    if (!init) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_ev    <= '0;
      for (int i = 0; i < 5; i++) r_dcnt[i] <= DB_LOAD;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      r_ev    <= r_deb & ~r_deb_d;
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_dcnt[i] <= DB_LOAD;
        end else if (r_dcnt[i] == '0) begin
          r_deb[i]  <= r_sync2[i];
          r_dcnt[i] <= DB_LOAD;
        end else begin
          r_dcnt[i] <= r_dcnt[i] - DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!init) begin
      for (int i = 0; i < 2; i++) begin
        r_rstate[i] <= RP_IDLE;
        r_rcnt[i]   <= DELAY_LOAD;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_rstate[i] <= w_rstate_nxt[i];
        r_rcnt[i]   <= w_rcnt_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_rstate_nxt[i] = r_rstate[i];
      w_rcnt_nxt[i]   = r_rcnt[i];
      w_rep[i]        = 1'b0;
      if (!r_deb[i]) begin
        w_rstate_nxt[i] = RP_IDLE;
        w_rcnt_nxt[i]   = DELAY_LOAD;
      end else begin
        case (r_rstate[i])
          RP_IDLE: begin
            if (r_ev[i]) begin
              w_rstate_nxt[i] = RP_HOLD;
              w_rcnt_nxt[i]   = DELAY_LOAD;
            end
          end
          RP_HOLD, RP_REPEAT: begin
            if (r_rcnt[i] == '0) begin
              w_rep[i]        = 1'b1;
              w_rstate_nxt[i] = RP_REPEAT;
              w_rcnt_nxt[i]   = RATE_LOAD;
            end else begin
              w_rcnt_nxt[i] = r_rcnt[i] - RW'(1);
            end
          end
          default: w_rstate_nxt[i] = RP_IDLE;
        endcase
      end
    end
  end

  assign w_loud    = r_ev[0] | w_rep[0];
  assign w_quiet   = r_ev[1] | w_rep[1];
  // widened sum so a step past the top saturates instead of wrapping
  assign w_att_sum = {1'b0, r_att} + {1'b0, VOL_STEP};
  assign w_att_dn  = (r_att < VOL_STEP) ? 8'h00 : r_att - VOL_STEP;
  assign w_att_up  = (w_att_sum > {1'b0, VOL_MAX_ATT}) ? VOL_MAX_ATT : w_att_sum[7:0];
  assign w_num_inc = (r_num == LAST_TRACK) ? 2'd0 : r_num + 2'd1;
  assign w_num_dec = (r_num == 2'd0) ? LAST_TRACK : r_num - 2'd1;

  always_comb begin
    w_att_nxt   = r_att;
    w_muted_nxt = r_muted;
    w_num_nxt   = r_num;
    if (r_ev[4]) begin
      w_muted_nxt = ~r_muted;
    end else if (w_loud ^ w_quiet) begin
      w_muted_nxt = 1'b0;
      w_att_nxt   = w_loud ? w_att_dn : w_att_up;
    end
    if (r_ev[2] ^ r_ev[3]) w_num_nxt = r_ev[2] ? w_num_inc : w_num_dec;
    w_vol_nxt = w_muted_nxt ? {VOL_MAX_ATT, VOL_MAX_ATT} : {w_att_nxt, w_att_nxt};
  end

  always_ff @(posedge clk) begin
    if (!init) begin
      r_att    <= VOL_INIT;
      r_muted  <= 1'b0;
      r_num    <= 2'd0;
      r_volume <= {VOL_INIT, VOL_INIT};
      r_upd    <= 1'b0;
    end else begin
      r_att    <= w_att_nxt;
      r_muted  <= w_muted_nxt;
      r_num    <= w_num_nxt;
      r_volume <= w_vol_nxt;
      r_upd    <= (w_vol_nxt != r_volume) || (w_num_nxt != r_num);
    end
  end

  assign volume = r_volume;
  assign num    = r_num;
  assign muted  = r_muted;
  assign upd    = r_upd;

endmodule

// File: tb/tb_mp3_ctrl_panel.sv
// Scoreboard bench for mp3_ctrl_panel: button presses are turned into event cycles by timing
// arithmetic, a reference model applies the volume/track/mute rules, a monitor checks every upd.
`timescale 1ns/1ps
module tb_mp3_ctrl_panel;
  localparam int D    = 4;
  localparam int RD   = 20;
  localparam int RR   = 5;
  localparam int MAXC = 6000;

  localparam logic [4:0] B_L = 5'b00001;
  localparam logic [4:0] B_Q = 5'b00010;
  localparam logic [4:0] B_N = 5'b00100;
  localparam logic [4:0] B_P = 5'b01000;
  localparam logic [4:0] B_M = 5'b10000;

  logic clk = 1'b0;
  logic init = 1'b0;
  logic btn_louder = 1'b0, btn_quieter = 1'b0, btn_next = 1'b0, btn_prev = 1'b0, btn_mute = 1'b0;
  logic [15:0] volume;
  logic [1:0]  num;
  logic        muted, upd;

  mp3_ctrl_panel #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .init(init),
    .btn_louder(btn_louder), .btn_quieter(btn_quieter), .btn_next(btn_next),
    .btn_prev(btn_prev), .btn_mute(btn_mute),
    .volume(volume), .num(num), .muted(muted), .upd(upd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // evmap[c][b]: button b delivers a (press or repeat) event during cycle c
  logic [4:0] evmap [MAXC];

  typedef struct {
    int          t;
    logic [15:0] vol;
    logic [1:0]  num;
    logic        muted;
  } exp_t;
  exp_t sbq[$];

  // reference model: applies the events of the cycle that ends at this edge
  int          m_att, m_num, m_num_prev, m_c;
  bit          m_muted, m_lo, m_qu;
  logic [4:0]  m_e;
  logic [7:0]  m_a8;
  logic [15:0] m_vol, m_vol_prev;
  exp_t        m_x;

  always @(posedge clk) begin
    m_c = cyc;
    if (!init) begin
      m_att = 8'h66; m_muted = 0; m_num = 0;
      m_vol_prev = 16'h6666; m_num_prev = 0;
      sbq.delete();
    end else if (m_c < MAXC) begin
      m_e  = evmap[m_c];
      m_lo = m_e[0];
      m_qu = m_e[1];
      if (m_e[4]) m_muted = !m_muted;
      else if (m_lo != m_qu) begin
        m_muted = 0;
        if (m_lo) m_att = (m_att < 16) ? 0 : m_att - 16;
        else      m_att = (m_att + 16 > 254) ? 254 : m_att + 16;
      end
      if (m_e[2] != m_e[3]) m_num = m_e[2] ? (m_num + 1) % 3 : (m_num + 2) % 3;
      m_a8  = m_att[7:0];
      m_vol = m_muted ? 16'hFEFE : {m_a8, m_a8};
      if (m_vol != m_vol_prev || m_num != m_num_prev) begin
        m_x.t = m_c + 1; m_x.vol = m_vol; m_x.num = 2'(m_num); m_x.muted = m_muted;
        sbq.push_back(m_x);
      end
      m_vol_prev = m_vol;
      m_num_prev = m_num;
    end
  end

  exp_t mon_x;
  always @(negedge clk) begin
    if (upd === 1'b1) begin
      n_checks++;
      if (sbq.size() == 0) begin
        n_errors++;
        $display("FAIL upd_unexpected cyc=%0d: got upd=1 vol=%h num=%0d, required upd=0", cyc, volume, num);
      end else begin
        mon_x = sbq.pop_front();
        if (mon_x.t != cyc || volume !== mon_x.vol || num !== mon_x.num || muted !== mon_x.muted) begin
          n_errors++;
          $display("FAIL sb_update: got cyc=%0d vol=%h num=%0d muted=%0b, required cyc=%0d vol=%h num=%0d muted=%0b",
                   cyc, volume, num, muted, mon_x.t, mon_x.vol, mon_x.num, mon_x.muted);
        end
      end
    end else if (sbq.size() > 0 && sbq[0].t <= cyc) begin
      mon_x = sbq.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL upd_missing cyc=%0d: got upd=%b vol=%h, required upd=1 vol=%h num=%0d",
               cyc, upd, volume, mon_x.vol, mon_x.num);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // a press held from cycle p to r (exclusive) debounces only if held at least D cycles;
  // the level goes low again at r+D+2, which also ends auto-repeat
  task automatic mark(input logic [4:0] m, input int p, input int r);
    int e, df;
    if (r - p < D) return;
    e  = p + D + 3;
    df = r + D + 2;
    for (int b = 0; b < 5; b++) begin
      if (m[b]) begin
        if (e < MAXC) evmap[e][b] = 1'b1;
        if (b < 2)
          for (int t = e + RD; t < df; t += RR)
            if (t < MAXC) evmap[t][b] = 1'b1;
      end
    end
  endtask

  task automatic set_btn(input logic [4:0] m, input logic v);
    if (m[0]) btn_louder  = v;
    if (m[1]) btn_quieter = v;
    if (m[2]) btn_next    = v;
    if (m[3]) btn_prev    = v;
    if (m[4]) btn_mute    = v;
  endtask

  task automatic press(input logic [4:0] m, input int hold, input int gap);
    mark(m, cyc, cyc + hold);
    set_btn(m, 1'b1);
    repeat (hold) @(negedge clk);
    set_btn(m, 1'b0);
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset(input int len);
    init = 1'b0;
    for (int k = cyc; k < MAXC; k++) evmap[k] = '0;
    repeat (len) @(negedge clk);
    init = 1'b1;
  endtask

  int p0;
  logic [4:0] rm;
  int sel;

  initial begin
    for (int k = 0; k < MAXC; k++) evmap[k] = '0;
    repeat (3) @(negedge clk);
    init = 1'b1;
    repeat (100) @(negedge clk);
    chk("reset_volume", volume, 16'h6666);
    chk("reset_num", num, 2'd0);
    chk("reset_muted", muted, 1'b0);

    // glitch shorter than the debounce window, then a clean 8-cycle press
    press(B_Q, 2, 6);
    p0 = cyc;
    mark(B_Q, p0, p0 + 8);
    btn_quieter = 1'b1;
    repeat (7) @(negedge clk);
    chk("latency_before", volume, 16'h6666);
    @(negedge clk);
    chk("latency_edge", {upd, volume}, {1'b1, 16'h7676});
    btn_quieter = 1'b0;
    repeat (12) @(negedge clk);

    press(B_L, 8, 12);
    chk("louder_once", volume, 16'h6666);
    press(B_L, 60, 12);
    chk("louder_sat", volume, 16'h0000);

    press(B_Q, 110, 12);
    chk("quieter_sat", volume, 16'hFEFE);
    press(B_L | B_Q, 8, 12);
    press(B_L | B_Q, 30, 12);
    chk("both_ignored", volume, 16'hFEFE);

    press(B_N, 6, 10); chk("next1", num, 2'd1);
    press(B_N, 6, 10); chk("next2", num, 2'd2);
    press(B_N, 6, 10); chk("next_wrap", num, 2'd0);
    press(B_P, 6, 10); chk("prev_wrap", num, 2'd2);
    press(B_N | B_P, 6, 10); chk("next_prev", num, 2'd2);

    do_reset(2);
    repeat (5) @(negedge clk);
    chk("rst2_volume", volume, 16'h6666);
    chk("rst2_num", num, 2'd0);
    press(B_M, 6, 10);
    chk("mute_vol", {muted, volume}, {1'b1, 16'hFEFE});
    press(B_L, 6, 10);
    chk("unmute_step", {muted, volume}, {1'b0, 16'h5656});
    press(B_M | B_L, 6, 10);
    chk("mute_wins", {muted, volume}, {1'b1, 16'hFEFE});
    press(B_M, 6, 10);
    chk("unmute_toggle", {muted, volume}, {1'b0, 16'h5656});

    // reset while louder sits in auto-repeat, button kept held across it
    p0 = cyc;
    mark(B_L, p0, p0 + 40);
    btn_louder = 1'b1;
    repeat (40) @(negedge clk);
    chk("pre_reset", volume, 16'h1616);
    do_reset(2);
    mark(B_L, cyc, cyc + 15);
    repeat (2) @(negedge clk);
    chk("held_rst_vol", volume, 16'h6666);
    chk("held_rst_num", num, 2'd0);
    repeat (13) @(negedge clk);
    btn_louder = 1'b0;
    repeat (12) @(negedge clk);
    chk("held_one_event", volume, 16'h5656);

    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(9, 0);
      case (sel)
        0, 1, 2, 3, 4: rm = 5'b00001 << sel;
        5:       rm = B_L | B_Q;
        6:       rm = B_N | B_P;
        7:       rm = B_M | B_L;
        8:       rm = B_M | B_Q;
        default: rm = B_Q;
      endcase
      press(rm, $urandom_range(70, 1), $urandom_range(14, D + 2));
    end

    repeat (30) @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
